vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, H/V counters, registered syncs, video_on, frame_start, blink.
// Optional macro VGA_BLINK_EN adds a frame counter driving blink; otherwise blink is held at 1.
module vga_sync_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_tick,
  output logic        h_sinc,
  output logic        v_sinc,
  output logic [10:0] countH,
  output logic [10:0] countV,
  output logic        video_on,
  output logic        frame_start,
  output logic        blink
);

  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        pix_tick_q;
  logic [10:0] countH_q, countH_d;
  logic [10:0] countV_q, countV_d;
  logic        h_sinc_q, h_sinc_d;
  logic        v_sinc_q, v_sinc_d;
  logic        video_on_q, video_on_d;
  logic        frame_start_q, frame_start_d;

  // Decode syncs/video_on from the next counter values so the registered
  // outputs line up with countH/countV in the same clk.
  always_comb begin
    countH_d      = countH_q;
    countV_d      = countV_q;
    frame_start_d = 1'b0;
    if (pix_tick_q) begin
      if (countH_q == H_LAST) begin
        countH_d = '0;
        if (countV_q == V_LAST) begin
          countV_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          countV_d = countV_q + 11'd1;
        end
      end else begin
        countH_d = countH_q + 11'd1;
      end
    end
    h_sinc_d   = !((countH_d >= H_SYNC_BEG) && (countH_d <= H_SYNC_END));
    v_sinc_d   = !((countV_d >= V_SYNC_BEG) && (countV_d <= V_SYNC_END));
    video_on_d = (countH_d < H_ACT) && (countV_d < V_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_tick_q    <= 1'b0;
      countH_q      <= '0;
      countV_q      <= '0;
      h_sinc_q      <= 1'b1;
      v_sinc_q      <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= !pix_tick_q;
      countH_q      <= countH_d;
      countV_q      <= countV_d;
      h_sinc_q      <= h_sinc_d;
      v_sinc_q      <= v_sinc_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;

  // blink flips on the same edge that raises the wrapping frame_start pulse.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start_d) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  // Digits always lit; BLINK_FRAMES has no effect in this build.
  assign blink = 1'b1 | (BLINK_FRAMES == 0);
`endif

  assign pix_tick    = pix_tick_q;
  assign countH      = countH_q;
  assign countV      = countV_q;
  assign h_sinc      = h_sinc_q;
  assign v_sinc      = v_sinc_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a scaled-down raster: 16 clocks-per-line ticks
// (8 active, 2 fp, 3 sync, 3 bp) x 10 lines (6 active, 1 fp, 2 sync, 1 bp), BLINK_FRAMES=3.
module tb_vga_sync_gen;

  logic        clk;
  logic        rst_n;
  logic        pix_tick;
  logic        h_sinc;
  logic        v_sinc;
  logic [10:0] countH;
  logic [10:0] countV;
  logic        video_on;
  logic        frame_start;
  logic        blink;

  int tests_run;
  int tests_failed;
  int cyc;

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BLINK_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_tick(pix_tick),
    .h_sinc(h_sinc),
    .v_sinc(v_sinc),
    .countH(countH),
    .countV(countV),
    .video_on(video_on),
    .frame_start(frame_start),
    .blink(blink)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset mid-cycle, hold two edges, release 1 time unit after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_pos(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      step();
      if (countH == 11'(h) && countV == 11'(v)) ok = 1'b1;
    end
  endtask

  task automatic measure(input bit vert, output int per, output int low, output bit ok);
    logic prev, cur;
    int t0, events;
    events = 0; per = 0; low = 0; t0 = 0;
    prev = vert ? v_sinc : h_sinc;
    for (int i = 0; i < 2000 && events < 3; i++) begin
      step();
      cur = vert ? v_sinc : h_sinc;
      if (prev && !cur) begin
        if (events == 0) begin t0 = cyc; events = 1; end
        else if (events == 2) begin per = cyc - t0; events = 3; end
      end else if (!prev && cur && events == 1) begin
        low = cyc - t0; events = 2;
      end
      prev = cur;
    end
    ok = (events == 3);
  endtask

  task automatic test_reset();
    logic exp_blink;
`ifdef VGA_BLINK_EN
    exp_blink = 1'b0;
`else
    exp_blink = 1'b1;
`endif
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({pix_tick, countH, countV, h_sinc, v_sinc, video_on, frame_start, blink} !==
        {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, exp_blink}) begin
      tests_failed++;
      $display("FAIL reset_values: got tick=%b h=%0d v=%0d hs=%b vs=%b von=%b fs=%b bl=%b, want 0 0 0 1 1 1 0 %b",
               pix_tick, countH, countV, h_sinc, v_sinc, video_on, frame_start, blink, exp_blink);
    end
  endtask

  // Release reset and follow an independent raster model for just over two frames.
  task automatic test_counters();
    logic exp_tick, exp_fs, exp_hs, exp_vs, exp_von;
    int eh, ev, fs_seen;
    exp_tick = 1'b0; eh = 0; ev = 0; fs_seen = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 700; i++) begin
      step();
      exp_fs = 1'b0;
      if (exp_tick) begin
        if (eh == 15) begin
          eh = 0;
          if (ev == 9) begin ev = 0; exp_fs = 1'b1; end
          else ev++;
        end else eh++;
      end
      exp_tick = !exp_tick;
      exp_hs  = !(eh >= 10 && eh <= 12);
      exp_vs  = !(ev >= 7 && ev <= 8);
      exp_von = (eh < 8) && (ev < 6);
      if (frame_start === 1'b1) fs_seen++;
      tests_run++;
      if ({pix_tick, countH, countV, frame_start, h_sinc, v_sinc, video_on} !==
          {exp_tick, 11'(eh), 11'(ev), exp_fs, exp_hs, exp_vs, exp_von}) begin
        tests_failed++;
        $display("FAIL raster cyc=%0d: got tick=%b h=%0d v=%0d fs=%b hs=%b vs=%b von=%b, want %b %0d %0d %b %b %b %b",
                 i + 1, pix_tick, countH, countV, frame_start, h_sinc, v_sinc, video_on,
                 exp_tick, eh, ev, exp_fs, exp_hs, exp_vs, exp_von);
      end
    end
    tests_run++;
    if (fs_seen != 2) begin
      tests_failed++;
      $display("FAIL frame_start_count: got %0d pulses, want 2", fs_seen);
    end
  endtask

  task automatic test_sync_timing();
    int per, low;
    bit ok;
    measure(1'b0, per, low, ok);
    tests_run++;
    if (!ok || per != 32 || low != 6) begin
      tests_failed++;
      $display("FAIL hsync_timing: got ok=%b period=%0d low=%0d, want 1 32 6", ok, per, low);
    end
    measure(1'b1, per, low, ok);
    tests_run++;
    if (!ok || per != 320 || low != 64) begin
      tests_failed++;
      $display("FAIL vsync_timing: got ok=%b period=%0d low=%0d, want 1 320 64", ok, per, low);
    end
  endtask

  task automatic test_video_points();
    bit ok;
    do_reset();
    wait_pos(8, 0, ok);
    tests_run++;
    if (!ok || video_on !== 1'b0) begin
      tests_failed++;
      $display("FAIL video_8_0: got found=%b von=%b, want 1 0", ok, video_on);
    end
    wait_pos(9, 0, ok);
    tests_run++;
    if (!ok || h_sinc !== 1'b1) begin
      tests_failed++;
      $display("FAIL hsync_9_0: got found=%b hs=%b, want 1 1", ok, h_sinc);
    end
    wait_pos(10, 0, ok);
    tests_run++;
    if (!ok || h_sinc !== 1'b0) begin
      tests_failed++;
      $display("FAIL hsync_10_0: got found=%b hs=%b, want 1 0", ok, h_sinc);
    end
    wait_pos(7, 5, ok);
    tests_run++;
    if (!ok || video_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL video_7_5: got found=%b von=%b, want 1 1", ok, video_on);
    end
    wait_pos(0, 6, ok);
    tests_run++;
    if (!ok || video_on !== 1'b0) begin
      tests_failed++;
      $display("FAIL video_0_6: got found=%b von=%b, want 1 0", ok, video_on);
    end
  endtask

  // Reset while in back porch of a vsync line; must clear without any clk edge.
  task automatic test_mid_sync_reset();
    bit ok;
    int per, low;
    wait_pos(14, 8, ok);
    tests_run++;
    if (!ok || v_sinc !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_reset_pos: got found=%b vs=%b, want 1 0", ok, v_sinc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pix_tick, countH, countV, h_sinc, v_sinc, video_on, frame_start} !==
        {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got tick=%b h=%0d v=%0d hs=%b vs=%b von=%b fs=%b, want 0 0 0 1 1 1 0",
               pix_tick, countH, countV, h_sinc, v_sinc, video_on, frame_start);
    end
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (pix_tick !== 1'b1 || countH !== 11'd0) begin
      tests_failed++;
      $display("FAIL first_edge: got tick=%b h=%0d, want 1 0", pix_tick, countH);
    end
    step();
    tests_run++;
    if (pix_tick !== 1'b0 || countH !== 11'd1 || countV !== 11'd0) begin
      tests_failed++;
      $display("FAIL second_edge: got tick=%b h=%0d v=%0d, want 0 1 0", pix_tick, countH, countV);
    end
    measure(1'b0, per, low, ok);
    tests_run++;
    if (!ok || per != 32 || low != 6) begin
      tests_failed++;
      $display("FAIL restart_hsync: got ok=%b period=%0d low=%0d, want 1 32 6", ok, per, low);
    end
  endtask

  task automatic test_blink();
    int pulses;
    logic exp_blink;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 7 * 320 + 40; i++) begin
      step();
`ifdef VGA_BLINK_EN
      if (frame_start === 1'b1) begin
        pulses++;
        exp_blink = ((pulses / 3) % 2) == 1;
        tests_run++;
        if (blink !== exp_blink) begin
          tests_failed++;
          $display("FAIL blink_pulse%0d: got %b, want %b", pulses, blink, exp_blink);
        end
      end
`else
      exp_blink = 1'b1;
      if (i % 200 == 0) begin
        tests_run++;
        if (blink !== exp_blink) begin
          tests_failed++;
          $display("FAIL blink_const cyc=%0d: got %b, want 1", i, blink);
        end
      end
`endif
    end
`ifdef VGA_BLINK_EN
    tests_run++;
    if (pulses != 7) begin
      tests_failed++;
      $display("FAIL blink_frames: got %0d frame pulses, want 7", pulses);
    end
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    rst_n = 1'b0;
    test_reset();
    test_counters();
    test_sync_timing();
    test_video_points();
    test_mid_sync_reset();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
